// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, stalling on mem_ready and trapping illegal opcodes.
module multicycle_controller #(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl_sig,
  output logic       halted
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BEQ, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  // Per-state Moore controls; fetch/branch are qualified by mem_ready/zero at the outputs.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       fetch;
    logic       pc_write;
    logic       branch;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       halted;
  } ctl_t;

  state_t state;
  ctl_t   ctl;
  logic   is_lw;

  function automatic state_t next_state(state_t s, logic [5:0] o, logic lw, logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (o)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_R:         n = S_EXEC;
          OP_BEQ:       n = S_BEQ;
          OP_ADDI:      n = S_ADDIEX;
          OP_J:         n = S_JUMP;
          default:      n = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: n = lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  n = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   n = S_ALUWB;
      S_ADDIEX: n = S_ADDIWB;
      S_HALT:   n = S_HALT;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_ALUWB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      S_BEQ:    begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1;
      end
      S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_HALT:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  // Controls are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ctl   <= state_ctl(S_FETCH);
      is_lw <= 1'b0;
    end else begin
      state <= next_state(state, op, is_lw, mem_ready);
      ctl   <= state_ctl(next_state(state, op, is_lw, mem_ready));
      if (state == S_DECODE) is_lw <= (op == OP_LW);
    end
  end

  always_comb begin
    alu_ctrl_sig = 3'b010;
    case (ctl.alu_op)
      2'b00: alu_ctrl_sig = 3'b010;
      2'b01: alu_ctrl_sig = 3'b110;
      default: begin
        case (funct)
          6'b100010: alu_ctrl_sig = 3'b110;
          6'b100100: alu_ctrl_sig = 3'b000;
          6'b100101: alu_ctrl_sig = 3'b001;
          6'b101010: alu_ctrl_sig = 3'b111;
          default:   alu_ctrl_sig = 3'b010;
        endcase
      end
    endcase
  end

  // Reset suppresses every side effect in the cycle it is asserted.
  assign mem_req    = ctl.mem_req & ~reset;
  assign mem_write  = ctl.mem_write & ~reset;
  assign ir_write   = ctl.fetch & mem_ready & ~reset;
  assign pc_en      = ~reset & ((ctl.fetch & mem_ready) | ctl.pc_write | (ctl.branch & zero));
  assign reg_write  = ctl.reg_write & ~reset;
  assign halted     = ctl.halted & ~reset;
  assign iord       = ctl.iord;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign pc_src     = ctl.pc_src;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction stream against a per-instruction transaction model, plus directed
// reset-in-wait and illegal-opcode halt sequences.
module tb_multicycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam int unsigned N_INSTR = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = OP_J;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b1;
  logic       mem_ready = 1'b0;
  logic       mem_req, iord, mem_write, ir_write, pc_en, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, halted;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl_sig;

  multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .pc_en(pc_en), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_ctrl_sig(alu_ctrl_sig), .halted(halted)
  );

  always #5 clk = ~clk;

  // What one instruction should look like, summarised over all of its cycles.
  typedef struct {
    int cycles;
    int reg_writes;
    int rd_dst;
    int m2r;
    int mem_writes;
    int data_reqs;
    int pc_ens;
    int jmp_src;
    int alu_ctrl;
    int ir_writes;
    int halted_cycles;
  } rec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t exp_q[$];
  int   wait_q[$];
  bit   mon_en = 1'b0;
  bit   resp_en = 1'b0;
  logic man_ready = 1'b1;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t fresh();
    rec_t r;
    r.cycles = 0; r.reg_writes = 0; r.rd_dst = -1; r.m2r = -1; r.mem_writes = 0;
    r.data_reqs = 0; r.pc_ens = 0; r.jmp_src = -1; r.alu_ctrl = -1; r.ir_writes = 0;
    r.halted_cycles = 0;
    return r;
  endfunction

  function automatic int funct_alu(logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return 2;
    endcase
  endfunction

  // Expected transaction from the instruction's opcode and the memory wait counts.
  function automatic rec_t model(logic [5:0] o, logic [5:0] f, logic z, int fw, int dw);
    rec_t r;
    r = fresh();
    r.ir_writes = 1;
    r.pc_ens = 1;
    case (o)
      OP_LW:   begin
        r.cycles = 5 + fw + dw; r.reg_writes = 1; r.rd_dst = 0; r.m2r = 1; r.data_reqs = 1 + dw;
      end
      OP_SW:   begin r.cycles = 4 + fw + dw; r.mem_writes = 1 + dw; r.data_reqs = 1 + dw; end
      OP_R:    begin
        r.cycles = 4 + fw; r.reg_writes = 1; r.rd_dst = 1; r.m2r = 0; r.alu_ctrl = funct_alu(f);
      end
      OP_ADDI: begin r.cycles = 4 + fw; r.reg_writes = 1; r.rd_dst = 0; r.m2r = 0; end
      OP_BEQ:  begin
        r.cycles = 3 + fw; r.alu_ctrl = 6;
        if (z) begin r.pc_ens = 2; r.jmp_src = 1; end
      end
      default: begin r.cycles = 3 + fw; r.pc_ens = 2; r.jmp_src = 2; end
    endcase
    return r;
  endfunction

  function automatic logic [5:0] pick_op(int t);
    case (t)
      0: return OP_LW;
      1: return OP_SW;
      2: return OP_R;
      3: return OP_ADDI;
      4: return OP_BEQ;
      default: return OP_J;
    endcase
  endfunction

  function automatic logic [5:0] pick_funct(int t);
    case (t)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  task automatic compare(rec_t a, rec_t e, int idx);
    check($sformatf("instr%0d cycles", idx), a.cycles, e.cycles);
    check($sformatf("instr%0d reg_write count", idx), a.reg_writes, e.reg_writes);
    check($sformatf("instr%0d reg_dst", idx), a.rd_dst, e.rd_dst);
    check($sformatf("instr%0d mem_to_reg", idx), a.m2r, e.m2r);
    check($sformatf("instr%0d mem_write cycles", idx), a.mem_writes, e.mem_writes);
    check($sformatf("instr%0d data access cycles", idx), a.data_reqs, e.data_reqs);
    check($sformatf("instr%0d pc_en count", idx), a.pc_ens, e.pc_ens);
    check($sformatf("instr%0d non-fetch pc_src", idx), a.jmp_src, e.jmp_src);
    check($sformatf("instr%0d alu_ctrl", idx), a.alu_ctrl, e.alu_ctrl);
    check($sformatf("instr%0d ir_write count", idx), a.ir_writes, e.ir_writes);
    check($sformatf("instr%0d halted cycles", idx), a.halted_cycles, e.halted_cycles);
  endtask

  // Memory model: each access is held off for its queued number of wait cycles.
  int resp_wait = 0;
  bit resp_busy = 1'b0;
  always @(posedge clk) begin
    #2;
    if (resp_en) begin
      if (mem_req) begin
        if (!resp_busy) begin
          resp_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
          resp_busy = 1'b1;
        end
        if (resp_wait == 0) begin
          mem_ready = 1'b1;
          resp_busy = 1'b0;
        end else begin
          mem_ready = 1'b0;
          resp_wait--;
        end
      end else begin
        mem_ready = 1'($urandom);
      end
    end else begin
      mem_ready = man_ready;
    end
  end

  // Monitor: an instruction starts at a fetch cycle not preceded by a stalled fetch.
  rec_t cur;
  rec_t exp_r;
  bit   open_seg = 1'b0;
  bit   prev_fw = 1'b0;
  int   n_closed = 0;
  always @(negedge clk) begin
    bit is_fetch;
    is_fetch = mem_req && !iord;
    if (mon_en) begin
      if (is_fetch && !prev_fw) begin
        if (open_seg && exp_q.size() > 0) begin
          exp_r = exp_q.pop_front();
          compare(cur, exp_r, n_closed);
          n_closed++;
        end
        cur = fresh();
        open_seg = 1'b1;
      end
      if (open_seg) begin
        cur.cycles++;
        if (reg_write) begin
          cur.reg_writes++;
          cur.rd_dst = int'(reg_dst);
          cur.m2r = int'(mem_to_reg);
        end
        if (mem_write) cur.mem_writes++;
        if (mem_req && iord) cur.data_reqs++;
        if (pc_en) begin
          cur.pc_ens++;
          if (!ir_write) cur.jmp_src = int'(pc_src);
        end
        if (alu_src_a && alu_src_b == 2'b00) cur.alu_ctrl = int'(alu_ctrl_sig);
        if (ir_write) cur.ir_writes++;
        if (halted) cur.halted_cycles++;
      end
    end else begin
      open_seg = 1'b0;
    end
    prev_fw = is_fetch && !mem_ready;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t e;
    int   fw, dw, k;
    logic [5:0] o;

    // Reset with mem_ready and zero high: nothing may be enabled.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_req", int'(mem_req), 0);
    check("reset ir_write", int'(ir_write), 0);
    check("reset pc_en", int'(pc_en), 0);
    check("reset writes", int'({mem_write, reg_write}), 0);
    check("reset halted", int'(halted), 0);

    @(posedge clk);
    #1;
    reset = 1'b0;
    resp_en = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < int'(N_INSTR); i++) begin
      o = pick_op(int'($urandom_range(0, 5)));
      op = o;
      funct = pick_funct(int'($urandom_range(0, 5)));
      zero = 1'($urandom);
      fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      dw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4)) : 0;
      wait_q.push_back(fw);
      if (o == OP_LW || o == OP_SW) wait_q.push_back(dw);
      e = model(o, funct, zero, fw, dw);
      exp_q.push_back(e);
      for (int j = 1; j < e.cycles; j++) begin
        @(posedge clk);
        #1;
        if (j >= fw + 2) op = 6'($urandom);
        if (j >= fw + 3) begin
          funct = 6'($urandom);
          zero = 1'($urandom);
        end
      end
      @(posedge clk);
      #1;
    end
    op = OP_J;
    funct = 6'd0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("scoreboard drained", exp_q.size(), 0);

    // Reset asserted while fetch is stalled, with mem_ready rising in the same cycle.
    @(posedge clk);
    #1;
    resp_en = 1'b0;
    man_ready = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req && !iord) break;
    end
    check("reach fetch wait", int'(k < 20), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    man_ready = 1'b1;
    @(negedge clk);
    check("reset in fetch ir_write", int'(ir_write), 0);
    check("reset in fetch pc_en", int'(pc_en), 0);
    check("reset in fetch mem_req", int'(mem_req), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    man_ready = 1'b0;
    @(negedge clk);
    check("after reset fetch", int'({mem_req, iord, ir_write}), 4);

    // Illegal opcode traps into a sticky HALT.
    @(posedge clk);
    #1;
    op = 6'b111111;
    man_ready = 1'b1;
    @(negedge clk);
    check("illegal fetch ir_write", int'(ir_write), 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      op = 6'($urandom);
      man_ready = 1'($urandom);
      @(negedge clk);
      check($sformatf("halt cycle%0d halted", i), int'(halted), 1);
      check($sformatf("halt cycle%0d enables", i),
            int'({mem_req, mem_write, ir_write, pc_en, reg_write}), 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    check("halt reset halted", int'(halted), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    man_ready = 1'b0;
    @(negedge clk);
    check("halt exit halted", int'(halted), 0);
    check("halt exit fetch", int'({mem_req, iord}), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
